// File: rtl/c3_bist_ctrl.sv
// Launch/capture self-test controller for the c3_slack block: LFSR-driven launch,
// one-cycle-later capture, golden compare and MISR compaction of the responses.
module c3_bist_ctrl #(
   parameter int unsigned PATTERNS = 15,
   parameter logic [3:0]  SEED     = 4'b0001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       nx1,
   output logic       nx2,
   output logic       nx3,
   output logic       nx4,
   input  logic       nx33,
   input  logic       nx44,
   input  logic       nx12,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_cnt,
   output logic [7:0] first_fail,
   output logic [7:0] signature
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LP_SEED  = (SEED == 4'b0000) ? 4'b0001 : SEED;
   localparam logic       LP_EMPTY = (PATTERNS == 0) ? 1'b1 : 1'b0;
   localparam logic [7:0] LP_LAST  = (PATTERNS == 0) ? 8'd0 : 8'(PATTERNS - 1);

   // Expected {nx33, nx44, nx12} for a launched vector {nx4, nx3, nx2, nx1}.
   function automatic logic [2:0] golden(input logic [3:0] l);
      return {~l[2], l[3], ~(l[0] & l[1])};
   endfunction

   function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [2:0] r);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {5'b00000, r};
   endfunction

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_lfsr;
   logic [7:0] r_idx;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [7:0] r_fail_cnt;
   logic [7:0] r_first_fail;
   logic [7:0] r_sig;
   logic [2:0] w_resp;
   logic       w_mismatch;
   logic [7:0] w_fail_nxt;

   assign w_resp     = {nx33, nx44, nx12};
   assign w_mismatch = (w_resp != golden(r_lfsr));
   assign w_fail_nxt = (w_mismatch && (r_fail_cnt != 8'hFF)) ? (r_fail_cnt + 8'd1) : r_fail_cnt;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; abort is only honoured while a run is active.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = LP_EMPTY ? ST_DONE : ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (r_idx == LP_LAST) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Launch register, capture/compare and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr       <= 4'b0000;
         r_idx        <= 8'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_cnt   <= 8'd0;
         r_first_fail <= 8'hFF;
         r_sig        <= 8'd0;
      end else begin
         r_busy <= (w_state_nxt == ST_RUN);
         r_done <= (w_state_nxt == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_lfsr       <= LP_EMPTY ? 4'b0000 : LP_SEED;
                  r_idx        <= 8'd0;
                  r_pass       <= LP_EMPTY;
                  r_fail_cnt   <= 8'd0;
                  r_first_fail <= 8'hFF;
                  r_sig        <= 8'd0;
               end else begin
                  r_lfsr <= 4'b0000;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_lfsr <= 4'b0000;
                  r_pass <= 1'b0;
               end else begin
                  r_fail_cnt <= w_fail_nxt;
                  r_sig      <= misr_step(r_sig, w_resp);
                  r_idx      <= r_idx + 8'd1;
                  if (w_mismatch && (r_first_fail == 8'hFF)) begin
                     r_first_fail <= r_idx;
                  end else begin
                     r_first_fail <= r_first_fail;
                  end
                  // Launch outputs drop to zero on the capture of the final pattern.
                  if (r_idx == LP_LAST) begin
                     r_lfsr <= 4'b0000;
                     r_pass <= (w_fail_nxt == 8'd0);
                  end else begin
                     r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
                  end
               end
            end
            ST_DONE: r_lfsr <= 4'b0000;
            default: r_lfsr <= 4'b0000;
         endcase
      end
   end

   assign nx1        = r_lfsr[0];
   assign nx2        = r_lfsr[1];
   assign nx3        = r_lfsr[2];
   assign nx4        = r_lfsr[3];
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign fail_cnt   = r_fail_cnt;
   assign first_fail = r_first_fail;
   assign signature  = r_sig;

endmodule

// File: tb/tb_c3_bist_ctrl.sv
// Directed bench for c3_bist_ctrl: three instances (15, 0 and 255 patterns) driving a
// behavioural c3_slack model with selectable stuck-at faults.
module tb_c3_bist_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Fault modes: 0 good, 1 nx12 stuck-at-1, 2 nx33 stuck-at-0, 3 nx44 always wrong.
   int fm15 = 0;

   function automatic logic [2:0] resp(input logic [3:0] v, input int fm);
      logic [2:0] r;
      r = {~v[2], v[3], ~(v[0] & v[1])};
      case (fm)
         1: r[0] = 1'b1;
         2: r[2] = 1'b0;
         3: r[1] = ~v[3];
         default: r = r;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] seq_at(input int k);
      case (k % 15)
         0: return 4'b0001;   1: return 4'b0010;   2: return 4'b0100;
         3: return 4'b1001;   4: return 4'b0011;   5: return 4'b0110;
         6: return 4'b1101;   7: return 4'b1010;   8: return 4'b0101;
         9: return 4'b1011;  10: return 4'b0111;  11: return 4'b1111;
        12: return 4'b1110;  13: return 4'b1100;  default: return 4'b1000;
      endcase
   endfunction

   function automatic logic [7:0] sig_model(input int n, input int fm);
      logic [7:0] s;
      s = 8'd0;
      for (int k = 0; k < n; k++) begin
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {5'b00000, resp(seq_at(k), fm)};
      end
      return s;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Instance with PATTERNS=15
   logic start15 = 1'b0, abort15 = 1'b0;
   logic a1, a2, a3, a4, a33, a44, a12, busy15, done15, pass15;
   logic [7:0] fail15, ff15, sig15;
   logic [3:0] nx15;
   assign nx15 = {a4, a3, a2, a1};
   assign {a33, a44, a12} = resp(nx15, fm15);

   c3_bist_ctrl #(.PATTERNS(15), .SEED(4'b0001)) u_dut15 (
      .clk(clk), .rst_n(rst_n), .start(start15), .abort(abort15),
      .nx1(a1), .nx2(a2), .nx3(a3), .nx4(a4),
      .nx33(a33), .nx44(a44), .nx12(a12),
      .busy(busy15), .done(done15), .pass(pass15),
      .fail_cnt(fail15), .first_fail(ff15), .signature(sig15));

   // Instance with PATTERNS=0
   logic start0 = 1'b0;
   logic b1, b2, b3, b4, b33, b44, b12, busy0, done0, pass0;
   logic [7:0] fail0, ff0, sig0;
   logic [3:0] nx0;
   assign nx0 = {b4, b3, b2, b1};
   assign {b33, b44, b12} = resp(nx0, 0);

   c3_bist_ctrl #(.PATTERNS(0), .SEED(4'b0001)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
      .nx1(b1), .nx2(b2), .nx3(b3), .nx4(b4),
      .nx33(b33), .nx44(b44), .nx12(b12),
      .busy(busy0), .done(done0), .pass(pass0),
      .fail_cnt(fail0), .first_fail(ff0), .signature(sig0));

   // Instance with PATTERNS=255, SEED=0 (mapped to 0001), permanently mismatching nx44
   logic start255 = 1'b0;
   logic c1, c2, c3, c4, c33, c44, c12, busy255, done255, pass255;
   logic [7:0] fail255, ff255, sig255;
   logic [3:0] nx255;
   assign nx255 = {c4, c3, c2, c1};
   assign {c33, c44, c12} = resp(nx255, 3);

   c3_bist_ctrl #(.PATTERNS(255), .SEED(4'b0000)) u_dut255 (
      .clk(clk), .rst_n(rst_n), .start(start255), .abort(1'b0),
      .nx1(c1), .nx2(c2), .nx3(c3), .nx4(c4),
      .nx33(c33), .nx44(c44), .nx12(c12),
      .busy(busy255), .done(done255), .pass(pass255),
      .fail_cnt(fail255), .first_fail(ff255), .signature(sig255));

   task automatic check_reset15(input string tag);
      check_val({tag, "_nx"}, nx15, 4'b0000);
      check_val({tag, "_busy"}, busy15, 1'b0);
      check_val({tag, "_done"}, done15, 1'b0);
      check_val({tag, "_pass"}, pass15, 1'b0);
      check_val({tag, "_fail"}, fail15, 8'd0);
      check_val({tag, "_ff"}, ff15, 8'hFF);
      check_val({tag, "_sig"}, sig15, 8'd0);
   endtask

   task automatic run_full15(input int fm, input logic [7:0] exp_fail, input logic [7:0] exp_ff,
                             input logic exp_pass, input string tag);
      fm15 = fm;
      @(negedge clk); start15 = 1'b1;
      @(negedge clk); start15 = 1'b0;
      for (int k = 0; k < 15; k++) begin
         check_val($sformatf("%s_nx%0d", tag, k), nx15, seq_at(k));
         check_val($sformatf("%s_busy%0d", tag, k), busy15, 1'b1);
         check_val($sformatf("%s_done%0d", tag, k), done15, 1'b0);
         @(negedge clk);
      end
      check_val({tag, "_done"}, done15, 1'b1);
      check_val({tag, "_busy_end"}, busy15, 1'b0);
      check_val({tag, "_nx_end"}, nx15, 4'b0000);
      check_val({tag, "_pass"}, pass15, exp_pass);
      check_val({tag, "_fail"}, fail15, exp_fail);
      check_val({tag, "_ff"}, ff15, exp_ff);
      check_val({tag, "_sig"}, sig15, sig_model(15, fm));
      @(negedge clk);
      check_val({tag, "_done_low"}, done15, 1'b0);
      check_val({tag, "_pass_hold"}, pass15, exp_pass);
   endtask

   initial begin
      int cnt;
      logic got;

      #12;
      check_reset15("rst");
      @(negedge clk); rst_n = 1'b1;

      run_full15(0, 8'd0, 8'hFF, 1'b1, "good");
      run_full15(1, 8'd4, 8'd4, 1'b0, "sa1_nx12");
      check_val("sa1_sig_vs_good", (sig15 != sig_model(15, 0)), 1'b1);
      run_full15(2, 8'd7, 8'd0, 1'b0, "sa0_nx33");

      // Abort during pattern 5 with a simultaneous (ignored) re-start
      fm15 = 0;
      @(negedge clk); start15 = 1'b1;
      @(negedge clk); start15 = 1'b0;
      repeat (5) @(negedge clk);
      check_val("abort_nx5", nx15, seq_at(5));
      abort15 = 1'b1; start15 = 1'b1;
      @(negedge clk);
      abort15 = 1'b0;
      check_val("abort_busy", busy15, 1'b0);
      check_val("abort_done", done15, 1'b0);
      check_val("abort_pass", pass15, 1'b0);
      check_val("abort_nx", nx15, 4'b0000);
      check_val("abort_ff", ff15, 8'hFF);
      check_val("abort_sig", sig15, sig_model(5, 0));
      @(negedge clk);
      start15 = 1'b0;
      check_val("restart_busy", busy15, 1'b1);
      check_val("restart_nx", nx15, seq_at(0));
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done15) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val("restart_done_seen", got, 1'b1);
      check_val("restart_pass", pass15, 1'b1);

      // Asynchronous reset mid-run
      fm15 = 1;
      @(negedge clk); start15 = 1'b1;
      @(negedge clk); start15 = 1'b0;
      repeat (6) @(negedge clk);
      check_val("midrun_fail", fail15, 8'd1);
      check_val("midrun_ff", ff15, 8'd4);
      check_val("midrun_busy", busy15, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset15("async_rst");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_busy", busy15, 1'b0);
      check_val("post_rst_nx", nx15, 4'b0000);

      // PATTERNS=0
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      check_val("p0_done", done0, 1'b1);
      check_val("p0_busy", busy0, 1'b0);
      check_val("p0_pass", pass0, 1'b1);
      check_val("p0_nx", nx0, 4'b0000);
      check_val("p0_ff", ff0, 8'hFF);
      @(negedge clk);
      check_val("p0_done_low", done0, 1'b0);
      check_val("p0_pass_hold", pass0, 1'b1);

      // PATTERNS=255 with every response wrong
      @(negedge clk); start255 = 1'b1;
      @(negedge clk); start255 = 1'b0;
      check_val("p255_nx0", nx255, 4'b0001);
      cnt = 0; got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done255) begin
            got = 1'b1;
            break;
         end
         if (busy255) cnt++;
         @(negedge clk);
      end
      check_val("p255_done_seen", got, 1'b1);
      check_val("p255_busy_cycles", cnt, 32'd255);
      check_val("p255_fail_sat", fail255, 8'd255);
      check_val("p255_ff", ff255, 8'd0);
      check_val("p255_pass", pass255, 1'b0);
      check_val("p255_sig", sig255, sig_model(255, 3));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/c3_bist_ctrl.md
Name: c3_bist_ctrl

Overview:
- Sequential launch/capture controller for the c3_slack combinational block. It is the driver of c3_slack's inputs and the reader of its outputs.
- Drives nx1..nx4 from a 4-bit LFSR and captures nx33/nx44/nx12 one cycle later.
- Checks each capture against the golden functions: nx33 = ~nx3, nx44 = nx4, nx12 = ~(nx1 & nx2).
- Compresses responses into a MISR signature. Used as the on-chip self-test wrapper and as the timing-benchmark launch/capture harness.

Parameters:
- PATTERNS, 15, number of vectors launched per run (0..255).
- SEED, 4'b0001, LFSR start value; 4'b0000 is replaced by 4'b0001.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous cancel of a run in progress
- nx1  out  1  launch bit, lfsr[0]
- nx2  out  1  launch bit, lfsr[1]
- nx3  out  1  launch bit, lfsr[2]
- nx4  out  1  launch bit, lfsr[3]
- nx33  in  1  captured response (INV path)
- nx44  in  1  captured response (BUF path)
- nx12  in  1  captured response (NAND path)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  last completed run had zero mismatches
- fail_cnt  out  8  mismatch count, saturating at 255
- first_fail  out  8  index of first mismatching pattern; 8'hFF if none
- signature  out  8  MISR result

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; nx1..nx4 = 0; busy = 0; done = 0; pass = 0; fail_cnt = 0; first_fail = 8'hFF; signature = 0.
- States:
  - IDLE: nx* = 0. On start=1 at edge E0: lfsr <= SEED (0 mapped to 1), idx <= 0, fail_cnt/signature cleared, first_fail <= FF, go to RUN. If PATTERNS == 0, go directly to DONE instead.
  - RUN: nx* = lfsr, registered so there are no glitches on the launch outputs. Pattern k is launched in the cycle after edge E_k.
    - At edge E_{k+1}: capture {nx33, nx44, nx12} for pattern k and compare against golden computed from the registered launch value.
    - On mismatch: fail_cnt++ (saturating); if first_fail == FF, first_fail <= k.
    - Update signature <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ {5'b0, nx33, nx44, nx12}.
    - Advance lfsr <= {l[2:0], l[3]^l[2]} (period 15); idx++.
    - At the edge capturing pattern PATTERNS-1, go to DONE.
  - DONE: one cycle. done = 1, busy = 0, pass = (fail_cnt == 0), nx* = 0. Next edge goes to IDLE.
- busy = 1 exactly in RUN, i.e. for PATTERNS cycles after E0.
- LFSR sequence from 0001: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then repeats. PATTERNS > 15 wraps and reuses the sequence.
- start while busy or in DONE: ignored.
- abort=1 in RUN: next edge goes to IDLE. No done pulse. pass, fail_cnt, first_fail and signature keep their partial values, and pass is forced to 0. abort in IDLE/DONE is ignored.
- start and abort both high in IDLE: start wins. abort only acts in RUN.
- Reset asserted mid-run: immediate return to reset values. The run is not resumed.
- pass, fail_cnt, first_fail and signature hold after DONE until the next start.

Test Plan:
- Good c3_slack attached, PATTERNS=15, start pulse -> busy high 15 cycles; nx{4,3,2,1} sequence matches the list above starting 0001; done pulse on cycle 16; pass=1, fail_cnt=0, first_fail=FF.
- nx12 forced stuck-at-1, PATTERNS=15 -> fail_cnt=4 (vectors 0011, 0111, 1011, 1111), first_fail=4 (0011 is pattern 4), pass=0. The signature differs from the good-run signature.
- nx33 forced stuck-at-0, PATTERNS=15 -> fail_cnt=7, first_fail=0 (0001 has nx3=0), pass=0.
- PATTERNS=0, start -> busy never asserts; done pulses the cycle after start; pass=1; nx* stay 0.
- Reset and control corner cases:
  - abort asserted during pattern 5 -> IDLE next edge, no done, pass=0.
  - Re-start in the same cycle as abort is ignored, then accepted one cycle later.
  - rst_n pulsed low mid-run -> all outputs return to reset values asynchronously.
- PATTERNS=255 with a permanently mismatching response -> fail_cnt saturates at 255, not 0; first_fail=0.
